draw_rect: RTL and testbench
============================

DRAW_RECT -- requirements
Module: draw_rect

Interface
REQ-001 SHALL provide parameter RECT_W, default 64, rectangle width in pixels (1..1023).
REQ-002 SHALL provide parameter RECT_H, default 48, rectangle height in pixels (1..767).
REQ-003 SHALL provide parameter RECT_COLOR, default 12'hF_0_0, rectangle fill colour (4:4:4 RGB).
REQ-004 SHALL provide parameter BORDER_COLOR, default 12'hF_F_F, border colour (used only with DRAW_RECT_BORDER_EN).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have inputs vcount_in[10:0], vsync_in, vblnk_in, hcount_in[10:0], hsync_in, hblnk_in: timing bus from the timing controller.
REQ-008 SHALL have input rgb_in[11:0]: upstream pixel colour aligned with the timing bus.
REQ-009 SHALL have outputs vcount_out[10:0], vsync_out, vblnk_out, hcount_out[10:0], hsync_out, hblnk_out, rgb_out[11:0]: delayed timing bus plus composited pixel.
REQ-010 SHALL have inputs pos_valid (1), xpos[10:0], ypos[10:0] and output pos_ready (1): rectangle top-left position update handshake.

Function
REQ-011 SHALL delay every timing-bus signal by exactly 2 clk cycles from input to output.
REQ-012 SHALL produce rgb_out 2 cycles after the corresponding rgb_in/hcount_in/vcount_in sample.
REQ-013 Stage 1 SHALL register timing bus and rgb_in and compute hit = (hcount_in >= x_act) && (hcount_in <= x_act+RECT_W-1) && (vcount_in >= y_act) && (vcount_in <= y_act+RECT_H-1).
REQ-014 Bound sums SHALL use 12-bit arithmetic; no wrap-around; parts beyond the visible area are clipped by never matching.
REQ-015 Stage 2 SHALL output rgb_out = 12'h000 if delayed hblnk or vblnk is 1; else RECT_COLOR if hit; else delayed rgb_in.
REQ-016 Position state: active regs x_act/y_act, pending regs x_pend/y_pend, flag pend.
REQ-017 pos_ready SHALL equal !pend when rst is 0, and 0 while rst is 1.
REQ-018 On pos_valid && pos_ready, SHALL load x_pend/y_pend from xpos/ypos and set pend next cycle.
REQ-019 Frame start SHALL be the cycle where vblnk_in is 1 and its previous registered value is 0.
REQ-020 On frame start with pend=1, SHALL copy pending to active regs and clear pend; active regs SHALL never change at any other time.
REQ-021 Handshake accept coinciding with frame start (pend=0) SHALL be captured into pending and applied at the next frame start, not the current one.
REQ-022 pos_valid while pos_ready=0 SHALL be ignored; upstream holds data until ready.
REQ-023 Multiple frame starts without a new accept SHALL leave active position unchanged.

Reset
REQ-024 During rst, all outputs SHALL be 0 (rgb_out=12'h000, counts 0, syncs/blanks 0) on the next edge.
REQ-025 Reset SHALL clear x_act, y_act, x_pend, y_pend to 0, pend to 0 and previous-vblnk register to 0.
REQ-026 Reset asserted mid-frame SHALL discard any pending update; first valid output 2 cycles after rst deasserts.

Configuration
REQ-027 Macro DRAW_RECT_BORDER_EN SHALL gate a 1-pixel border feature.
REQ-028 With DRAW_RECT_BORDER_EN defined, hit pixels on first/last column or row of the rectangle SHALL output BORDER_COLOR, interior RECT_COLOR.
REQ-029 Without DRAW_RECT_BORDER_EN, BORDER_COLOR SHALL be unused and all hit pixels SHALL output RECT_COLOR; latency unchanged.

Verification
REQ-030 Reset then free-running 1024x768 timing, rgb_in=12'h0F0 -> outputs equal inputs delayed 2 cycles; rect at (0,0) 64x48 gives rgb_out=12'hF00 for h 0..63, v 0..47, 12'h0F0 elsewhere visible, 12'h000 in blanking.
REQ-031 Accept pos (100,200) mid-frame -> pos_ready drops next cycle; rectangle unchanged until next vblnk_in rise, then drawn at h 100..163, v 200..247; pos_ready returns to 1.
REQ-032 pos_valid held on frame-start cycle with pend=0 -> new position appears one frame later, not immediately.
REQ-033 Position (1000,750) -> drawn only h 1000..1023, v 750..767; no wrap to h/v 0.
REQ-034 rst pulsed 1 cycle mid-frame with pend=1 -> outputs 0, pend cleared, rectangle back at (0,0), pos_ready=1 after rst.
REQ-035 With DRAW_RECT_BORDER_EN, rect at (10,10) -> pixel (10,10) and (73,57) = 12'hFFF, (11,11) = 12'hF00.

Source files
------------

// File: rtl/draw_rect.sv
// Overlays a filled rectangle on a pixel stream with a two-stage pipeline.
// The top-left position is updated through a valid/ready handshake and
// takes effect only at the next frame start.
// Optional feature macro: DRAW_RECT_BORDER_EN adds a 1-pixel border in BORDER_COLOR.
module draw_rect #(
  parameter int unsigned RECT_W       = 64,
  parameter int unsigned RECT_H       = 48,
  parameter logic [11:0] RECT_COLOR   = 12'hF00,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  input  logic        pos_valid,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  output logic        pos_ready
);

  // Position state
  logic [10:0] x_act_q, y_act_q, x_pend_q, y_pend_q;
  logic        pend_q;

  // Stage 1 registers; vblnk_q doubles as the previous-vblnk register
  logic [10:0] vcount_q, hcount_q;
  logic        vsync_q, vblnk_q, hsync_q, hblnk_q;
  logic [11:0] rgb_q;
  logic        hit_q, border_q;

  logic [11:0] x_end, y_end, h_ext, v_ext;
  logic        hit_d, border_d, frame_start, accept;
  logic [11:0] rgb_d;

  assign pos_ready   = ~pend_q & ~rst;
  assign accept      = pos_valid & pos_ready;
  assign frame_start = vblnk_in & ~vblnk_q;

  // 12-bit bounds: the far edge can exceed the screen but never wraps to zero
  always_comb begin
    x_end = {1'b0, x_act_q} + 12'(RECT_W) - 12'd1;
    y_end = {1'b0, y_act_q} + 12'(RECT_H) - 12'd1;
    h_ext = {1'b0, hcount_in};
    v_ext = {1'b0, vcount_in};
    hit_d = (hcount_in >= x_act_q) && (h_ext <= x_end) &&
            (vcount_in >= y_act_q) && (v_ext <= y_end);
    border_d = 1'b0;
`ifdef DRAW_RECT_BORDER_EN
    border_d = (hcount_in == x_act_q) || (h_ext == x_end) ||
               (vcount_in == y_act_q) || (v_ext == y_end);
`endif
  end

`ifndef DRAW_RECT_BORDER_EN
  logic unused_border;
  assign unused_border = ^BORDER_COLOR;
`endif

  // Position handshake and frame-synchronous update of the active position
  always_ff @(posedge clk) begin
    if (rst) begin
      x_act_q  <= '0;
      y_act_q  <= '0;
      x_pend_q <= '0;
      y_pend_q <= '0;
      pend_q   <= 1'b0;
    end else if (accept) begin
      x_pend_q <= xpos;
      y_pend_q <= ypos;
      pend_q   <= 1'b1;
    end else if (frame_start && pend_q) begin
      x_act_q <= x_pend_q;
      y_act_q <= y_pend_q;
      pend_q  <= 1'b0;
    end
  end

  // Stage 1: register timing bus and hit test
  always_ff @(posedge clk) begin
    if (rst) begin
      vcount_q <= '0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      hcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      rgb_q    <= '0;
      hit_q    <= 1'b0;
      border_q <= 1'b0;
    end else begin
      vcount_q <= vcount_in;
      vsync_q  <= vsync_in;
      vblnk_q  <= vblnk_in;
      hcount_q <= hcount_in;
      hsync_q  <= hsync_in;
      hblnk_q  <= hblnk_in;
      rgb_q    <= rgb_in;
      hit_q    <= hit_d;
      border_q <= border_d;
    end
  end

  // Stage 2 pixel select: blanking, then rectangle, then passthrough
  always_comb begin
    rgb_d = rgb_q;
    if (hblnk_q || vblnk_q) begin
      rgb_d = 12'h000;
    end else if (hit_q) begin
      rgb_d = border_q ? BORDER_COLOR : RECT_COLOR;
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      vcount_out <= vcount_q;
      vsync_out  <= vsync_q;
      vblnk_out  <= vblnk_q;
      hcount_out <= hcount_q;
      hsync_out  <= hsync_q;
      hblnk_out  <= hblnk_q;
      rgb_out    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_rect.sv
// Directed bench for draw_rect with default parameters (64x48, F00 fill).
module tb_draw_rect;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] vcount_in, hcount_in, vcount_out, hcount_out, xpos, ypos;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic        pos_valid, pos_ready;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [11:0] Bg   = 12'h0F0;
  localparam logic [11:0] Fill = 12'hF00;
`ifdef DRAW_RECT_BORDER_EN
  localparam logic [11:0] Edge = 12'hFFF;
`else
  localparam logic [11:0] Edge = 12'hF00;
`endif

  always #5 clk = ~clk;

  draw_rect dut (
    .clk       (clk),
    .rst       (rst),
    .vcount_in (vcount_in),
    .vsync_in  (vsync_in),
    .vblnk_in  (vblnk_in),
    .hcount_in (hcount_in),
    .hsync_in  (hsync_in),
    .hblnk_in  (hblnk_in),
    .rgb_in    (rgb_in),
    .vcount_out(vcount_out),
    .vsync_out (vsync_out),
    .vblnk_out (vblnk_out),
    .hcount_out(hcount_out),
    .hsync_out (hsync_out),
    .hblnk_out (hblnk_out),
    .rgb_out   (rgb_out),
    .pos_valid (pos_valid),
    .xpos      (xpos),
    .ypos      (ypos),
    .pos_ready (pos_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one pixel on the bus for two cycles and check the composited colour
  task automatic probe(input string tag, input int h, input int v, input logic hb,
                       input logic vb, input logic [11:0] exp);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = Bg;
    tick();
    tick();
    check_eq(tag, {20'd0, rgb_out}, {20'd0, exp});
  endtask

  task automatic frame_start();
    vblnk_in = 1'b0;
    tick();
    vblnk_in = 1'b1;
    tick();
    vblnk_in = 1'b0;
    tick();
  endtask

  task automatic accept(input int x, input int y);
    pos_valid = 1'b1;
    xpos      = 11'(x);
    ypos      = 11'(y);
    tick();
    pos_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = 11'd5; vcount_in = 11'd7; rgb_in = Bg;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
    pos_valid = 1'b0; xpos = '0; ypos = '0;
    tick();
    tick();
    check_eq("rst_rgb", {20'd0, rgb_out}, 32'd0);
    check_eq("rst_hcount", {21'd0, hcount_out}, 32'd0);
    check_eq("rst_sync", {30'd0, hsync_out, vsync_out}, 32'd0);
    check_eq("rst_ready", {31'd0, pos_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", {31'd0, pos_ready}, 32'd1);

    // Two-cycle latency of every bus field with changing values
    for (int i = 0; i < 6; i++) begin
      hcount_in = 11'(300 + i * 7);
      vcount_in = 11'(100 + i);
      hsync_in  = i[0];
      vsync_in  = i[1];
      rgb_in    = 12'(12'h0F0 + i);
      tick();
      if (i >= 1) begin
        check_eq("lat_hcount", {21'd0, hcount_out}, 32'(300 + (i - 1) * 7));
        check_eq("lat_vcount", {21'd0, vcount_out}, 32'(100 + i - 1));
        check_eq("lat_syncs", {30'd0, vsync_out, hsync_out}, 32'((i - 1) & 3));
        check_eq("lat_rgb", {20'd0, rgb_out}, 32'(12'h0F0 + i - 1));
      end
    end
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Default rectangle at (0,0)
    probe("r0_tl", 0, 0, 1'b0, 1'b0, Edge);
    probe("r0_br", 63, 47, 1'b0, 1'b0, Edge);
    probe("r0_in", 1, 1, 1'b0, 1'b0, Fill);
    probe("r0_right", 64, 47, 1'b0, 1'b0, Bg);
    probe("r0_below", 63, 48, 1'b0, 1'b0, Bg);
    probe("hblank", 10, 10, 1'b1, 1'b0, 12'h000);
    probe("vblank", 10, 10, 1'b0, 1'b1, 12'h000);
    vblnk_in = 1'b0;
    tick();

    // Mid-frame accept applies only at the next frame start
    accept(100, 200);
    check_eq("ready_drop", {31'd0, pos_ready}, 32'd0);
    probe("pend_old", 0, 0, 1'b0, 1'b0, Edge);
    probe("pend_new", 100, 200, 1'b0, 1'b0, Bg);
    frame_start();
    check_eq("ready_back", {31'd0, pos_ready}, 32'd1);
    probe("r1_tl", 100, 200, 1'b0, 1'b0, Edge);
    probe("r1_br", 163, 247, 1'b0, 1'b0, Edge);
    probe("r1_in", 101, 201, 1'b0, 1'b0, Fill);
    probe("r1_right", 164, 200, 1'b0, 1'b0, Bg);
    probe("r1_below", 100, 248, 1'b0, 1'b0, Bg);
    probe("r1_old", 0, 0, 1'b0, 1'b0, Bg);

    // Another frame start with nothing pending keeps the position
    frame_start();
    probe("r1_keep", 100, 200, 1'b0, 1'b0, Edge);

    // Accept coinciding with frame start is deferred one frame
    vblnk_in = 1'b0;
    tick();
    vblnk_in  = 1'b1;
    pos_valid = 1'b1;
    xpos      = 11'd1000;
    ypos      = 11'd750;
    tick();
    pos_valid = 1'b0;
    vblnk_in  = 1'b0;
    check_eq("coin_ready", {31'd0, pos_ready}, 32'd0);
    probe("coin_old", 100, 200, 1'b0, 1'b0, Edge);
    probe("coin_new", 1001, 751, 1'b0, 1'b0, Bg);
    frame_start();
    probe("r2_tl", 1000, 750, 1'b0, 1'b0, Edge);
    probe("r2_br", 1023, 767, 1'b0, 1'b0, Fill);
    probe("r2_left", 999, 750, 1'b0, 1'b0, Bg);
    probe("r2_above", 1000, 749, 1'b0, 1'b0, Bg);
    probe("r2_nowrap", 0, 0, 1'b0, 1'b0, Bg);
    probe("r2_nowrap2", 5, 5, 1'b0, 1'b0, Bg);

    // One-cycle reset with a pending update discards it
    accept(300, 300);
    hcount_in = 11'd400;
    rst = 1'b1;
    tick();
    check_eq("mid_rst_rgb", {20'd0, rgb_out}, 32'd0);
    check_eq("mid_rst_hcount", {21'd0, hcount_out}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, pos_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", {31'd0, pos_ready}, 32'd1);
    probe("post_rst_home", 0, 0, 1'b0, 1'b0, Edge);
    frame_start();
    probe("post_rst_nopend", 301, 301, 1'b0, 1'b0, Bg);
    probe("post_rst_home2", 2, 2, 1'b0, 1'b0, Fill);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
